matmul_job_sched: RTL and testbench

//  Shares the single matmul core (start/done handshake) between NREQ requesters.

---
 rtl/matmul_pkg.sv | 14 +
 rtl/matmul_job_sched_rr_arbiter.sv | 27 ++
 rtl/matmul_job_sched.sv | 126 ++++++++++++
 tb/tb_matmul_job_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types for the matmul job scheduler: FSM state encoding and default watchdog depth.
package matmul_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StStart,
    StRun,
    StResp
  } sched_state_t;

  localparam int unsigned DefaultTimeout = 64;

endpackage

// File: rtl/matmul_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned SelW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SelW-1:0] ptr,
  output logic            any,
  output logic [SelW-1:0] winner
);

  int unsigned idx;

  // Walk from the farthest candidate back to ptr so the nearest one wins last.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + (NREQ - 1 - k)) % NREQ;
      if (req[SelW'(idx)]) begin
        winner = SelW'(idx);
      end
    end
  end

endmodule

// File: rtl/matmul_job_sched.sv
// Round-robin scheduler sharing one matmul core between NREQ requesters, with a RUN watchdog.
module matmul_job_sched
  import matmul_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  localparam int unsigned SEL_W  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  resp_valid,
  input  logic [NREQ-1:0]  resp_ready,
  output logic             resp_err,
  output logic [SEL_W-1:0] sel,
  output logic             core_start,
  input  logic             core_done,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SelLast = SEL_W'(NREQ - 1);

  sched_state_t     state_q, state_d;
  logic [SEL_W-1:0] sel_q, ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             resp_err_q, timeout_err_q;

  logic             arb_any;
  logic [SEL_W-1:0] arb_winner;
  logic             timeout_hit;
  logic             resp_hs;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .any    (arb_any),
    .winner (arb_winner)
  );

  // core_done on the last allowed RUN cycle counts as success, not an abort.
  assign timeout_hit = (state_q == StRun) && !core_done && (cnt_q == CntLast);
  assign resp_hs     = (state_q == StResp) && resp_ready[sel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (arb_any) state_d = StGrant;
      StGrant: state_d = req_valid[sel_q] ? StStart : StIdle;
      StStart: state_d = StRun;
      StRun:   if (core_done || timeout_hit) state_d = StResp;
      StResp:  if (resp_ready[sel_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    core_start = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StGrant: req_ready[sel_q] = 1'b1;
      StStart: core_start = 1'b1;
      StResp:  resp_valid[sel_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q         <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      resp_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && arb_any) begin
        sel_q <= arb_winner;
      end

      if (state_q == StStart) begin
        cnt_q <= '0;
      end else if ((state_q == StRun) && !core_done && (cnt_q != CntLast)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if ((state_q == StRun) && core_done) begin
        resp_err_q <= 1'b0;
      end else if (timeout_hit) begin
        resp_err_q <= 1'b1;
      end else if (resp_hs) begin
        resp_err_q <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end else if (err_clr) begin
        timeout_err_q <= 1'b0;
      end

      if (resp_hs) begin
        ptr_q <= (sel_q == SelLast) ? '0 : sel_q + 1'b1;
      end
    end
  end

  assign sel         = sel_q;
  assign resp_err    = resp_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// Self-checking bench for matmul_job_sched: directed scenarios plus randomized jobs vs a model.
module tb_matmul_job_sched;

  localparam int unsigned NREQ = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic       resp_err;
  logic [0:0] sel;
  logic       core_start, core_done, busy, timeout_err, err_clr;

  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  logic terr_m = 1'b0;
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  matmul_job_sched #(
    .NREQ    (NREQ),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_err    (resp_err),
    .sel         (sel),
    .core_start  (core_start),
    .core_done   (core_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic int model_winner(input logic [1:0] rv, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i = (p + k) % NREQ;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  // Every cycle step also checks the one-hot and single-cycle-start properties.
  task automatic tick();
    @(posedge clk);
    #1;
    total += 3;
    if (!$onehot0(req_ready)) begin
      bad++; $display("FAIL req_ready_onehot0 got=%b required=onehot0", req_ready);
    end
    if (!$onehot0(resp_valid)) begin
      bad++; $display("FAIL resp_valid_onehot0 got=%b required=onehot0", resp_valid);
    end
    if (core_start && prev_start) begin
      bad++; $display("FAIL core_start_width got=2+ cycles required=1");
    end
    prev_start = core_start;
  endtask

  task automatic do_job(input logic [1:0] rv, input bit hold, input int d, input int rdy_lat,
                        input bit clr_run, input bit done_resp,
                        output logic [1:0] gnt, output int gsel, output int gwait,
                        output logic started, output int run_cyc, output logic [1:0] resp,
                        output logic err, output logic terr, output int held,
                        output logic busy_after, output logic [1:0] rv_after, output bit to);
    to = 0; gnt = '0; gsel = -1; gwait = 0; started = 0; run_cyc = 0; resp = '0;
    err = 0; terr = 0; held = 0; busy_after = 1; rv_after = '0;
    req_valid = rv;
    for (int k = 0; k < 4 && gnt == 0; k++) begin
      tick();
      gwait = k + 1;
      if (req_ready != 0) begin
        gnt = req_ready;
        gsel = int'(sel);
      end
    end
    if (gnt == 0) begin
      to = 1; req_valid = '0; return;
    end
    tick();
    started = core_start;
    if (!hold) req_valid = '0;
    err_clr = clr_run;
    tick();
    for (int i = 0; i < 40 && resp == 0; i++) begin
      core_done = (i == d);
      tick();
      core_done = 1'b0;
      run_cyc = i + 1;
      if (resp_valid != 0) begin
        resp = resp_valid; err = resp_err; terr = timeout_err;
      end
    end
    err_clr = 1'b0;
    if (resp == 0) begin
      to = 1; return;
    end
    for (int i = 0; i < rdy_lat; i++) begin
      resp_ready = ~resp;
      core_done = done_resp && (i == 0);
      tick();
      core_done = 1'b0;
      if (resp_valid == resp) held++;
    end
    resp_ready = resp;
    tick();
    resp_ready = '0;
    busy_after = busy;
    rv_after = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; resp_ready = '0; core_done = 1'b0; err_clr = 1'b0;
    tick();
    total += 7;
    if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b required=00", req_ready); end
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b required=00", resp_valid); end
    if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b required=0", resp_err); end
    if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b required=0", core_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b required=0", timeout_err); end
    if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b required=0", sel); end
    rst = 1'b0;
    ptr_m = 0; terr_m = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held; logic st, err, terr, ba; bit to;
    do_job(2'b01, 0, 2, 5, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    total += 10;
    if (to) begin bad++; $display("FAIL single_timeout got=stalled required=complete"); end
    if (gnt !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%b required=01", gnt); end
    if (gw != 1) begin bad++; $display("FAIL single_grant_latency got=%0d required=1", gw); end
    if (st !== 1'b1) begin bad++; $display("FAIL single_core_start got=%b required=1", st); end
    if (rc != 3) begin bad++; $display("FAIL single_run_cycles got=%0d required=3", rc); end
    if (resp !== 2'b01) begin bad++; $display("FAIL single_resp_valid got=%b required=01", resp); end
    if (err !== 1'b0) begin bad++; $display("FAIL single_resp_err got=%b required=0", err); end
    if (held != 5) begin bad++; $display("FAIL single_resp_held got=%0d required=5", held); end
    if (ba !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b required=0", ba); end
    if (rva !== 2'b00) begin bad++; $display("FAIL single_resp_after got=%b required=00", rva); end
    ptr_m = 1;
  endtask

  task automatic test_alternate();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held, exp; logic st, err, terr, ba; bit to;
    for (int n = 0; n < 4; n++) begin
      exp = model_winner(2'b11, ptr_m);
      do_job(2'b11, 1, 0, 0, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
      total += 3;
      if (to) begin bad++; $display("FAIL alt_timeout job=%0d got=stalled required=complete", n); end
      if (gsel != exp || gnt !== 2'(1 << exp)) begin
        bad++; $display("FAIL alt_grant job=%0d got=sel%0d/%b required=sel%0d", n, gsel, gnt, exp);
      end
      if (resp !== 2'(1 << exp)) begin
        bad++; $display("FAIL alt_resp job=%0d got=%b required=%0d-hot", n, resp, exp);
      end
      ptr_m = (exp + 1) % NREQ;
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held, exp; logic st, err, terr, ba; bit to;
    exp = model_winner(2'b01, ptr_m);
    do_job(2'b01, 0, -1, 2, 1, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    ptr_m = (exp + 1) % NREQ;
    total += 6;
    if (to) begin bad++; $display("FAIL tmo_stall got=stalled required=abort"); end
    if (rc != TO) begin bad++; $display("FAIL tmo_run_cycles got=%0d required=%0d", rc, TO); end
    if (err !== 1'b1) begin bad++; $display("FAIL tmo_resp_err got=%b required=1", err); end
    if (terr !== 1'b1) begin bad++; $display("FAIL tmo_set_over_clr got=%b required=1", terr); end
    if (resp !== 2'b01) begin bad++; $display("FAIL tmo_resp_valid got=%b required=01", resp); end
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b required=1", timeout_err); end
    tick();
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky2 got=%b required=1", timeout_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b required=0", timeout_err); end
    // Done on the very last RUN cycle must win over the abort.
    exp = model_winner(2'b10, ptr_m);
    do_job(2'b10, 0, TO - 1, 0, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    ptr_m = (exp + 1) % NREQ;
    total += 4;
    if (to) begin bad++; $display("FAIL edge_stall got=stalled required=complete"); end
    if (rc != TO) begin bad++; $display("FAIL edge_run_cycles got=%0d required=%0d", rc, TO); end
    if (err !== 1'b0) begin bad++; $display("FAIL edge_resp_err got=%b required=0", err); end
    if (terr !== 1'b0) begin bad++; $display("FAIL edge_timeout_err got=%b required=0", terr); end
  endtask

  task automatic test_withdraw();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held; logic st, err, terr, ba; bit to;
    if (ptr_m != 1) begin
      do_job(2'b01, 0, 0, 0, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
      ptr_m = 1;
    end
    req_valid = 2'b10;
    tick();
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL wd_grant got=%b required=10", req_ready); end
    req_valid = 2'b00;
    tick();
    total += 2;
    if (core_start !== 1'b0) begin bad++; $display("FAIL wd_core_start got=%b required=0", core_start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL wd_busy got=%b required=0", busy); end
    req_valid = 2'b11;
    tick();
    total++;
    if (req_ready !== 2'(1 << model_winner(2'b11, ptr_m))) begin
      bad++; $display("FAIL wd_ptr_kept got=%b required=grant to %0d", req_ready, ptr_m);
    end
    req_valid = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wd_busy2 got=%b required=0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held, exp; logic st, err, terr, ba; bit to;
    req_valid = 2'b01;
    tick(); tick();
    req_valid = 2'b00;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    ptr_m = 0; terr_m = 1'b0;
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy got=%b required=0", busy); end
    if (req_ready !== 2'b00) begin bad++; $display("FAIL rr_req_ready got=%b required=00", req_ready); end
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL rr_resp_valid got=%b required=00", resp_valid); end
    if (core_start !== 1'b0) begin bad++; $display("FAIL rr_core_start got=%b required=0", core_start); end
    if (resp_err !== 1'b0) begin bad++; $display("FAIL rr_resp_err got=%b required=0", resp_err); end
    if (sel !== 1'b0) begin bad++; $display("FAIL rr_sel got=%b required=0", sel); end
    exp = model_winner(2'b11, ptr_m);
    do_job(2'b11, 0, 1, 0, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    ptr_m = (exp + 1) % NREQ;
    total++;
    if (to || gsel != exp) begin bad++; $display("FAIL rr_ptr_reset got=sel%0d required=sel%0d", gsel, exp); end
    exp = model_winner(2'b01, ptr_m);
    do_job(2'b01, 0, 4, 0, 0, 0, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    ptr_m = (exp + 1) % NREQ;
    total += 2;
    if (to || resp !== 2'b01) begin bad++; $display("FAIL rr_new_job got=%b required=01", resp); end
    if (rc != 5 || err !== 1'b0) begin bad++; $display("FAIL rr_new_run got=%0d/%b required=5/0", rc, err); end
  endtask

  task automatic test_stray_done();
    logic [1:0] gnt, resp, rva; int gsel, gw, rc, held, exp; logic st, err, terr, ba; bit to;
    core_done = 1'b1; tick(); core_done = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL sd_idle_busy got=%b required=0", busy); end
    if (resp_valid !== 2'b00) begin bad++; $display("FAIL sd_idle_resp got=%b required=00", resp_valid); end
    exp = model_winner(2'b10, ptr_m);
    do_job(2'b10, 0, 3, 2, 0, 1, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
    ptr_m = (exp + 1) % NREQ;
    total += 3;
    if (to || held != 2) begin bad++; $display("FAIL sd_resp_held got=%0d required=2", held); end
    if (rva !== 2'b00) begin bad++; $display("FAIL sd_extra_resp got=%b required=00", rva); end
    if (ba !== 1'b0) begin bad++; $display("FAIL sd_busy_after got=%b required=0", ba); end
  endtask

  task automatic test_random();
    logic [1:0] gnt, resp, rva, rv; int gsel, gw, rc, held, exp, d, rdy, exp_rc;
    logic st, err, terr, ba, exp_err; bit to, hold, dr;
    for (int n = 0; n < 30; n++) begin
      rv = 2'($urandom_range(1, 3));
      hold = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 19);
      rdy = $urandom_range(0, 3);
      dr = (rdy > 0) && ($urandom_range(0, 1) == 1);
      exp = model_winner(rv, ptr_m);
      exp_err = !(d < TO);
      exp_rc = exp_err ? TO : d + 1;
      if (exp_err) terr_m = 1'b1;
      do_job(rv, hold, d, rdy, 0, dr, gnt, gsel, gw, st, rc, resp, err, terr, held, ba, rva, to);
      req_valid = '0;
      ptr_m = (exp + 1) % NREQ;
      total += 5;
      if (to) begin bad++; $display("FAIL rnd_stall job=%0d got=stalled required=complete", n); end
      if (gsel != exp || resp !== 2'(1 << exp)) begin
        bad++; $display("FAIL rnd_grant job=%0d rv=%b got=sel%0d resp=%b required=sel%0d", n, rv, gsel, resp, exp);
      end
      if (rc != exp_rc || err !== exp_err) begin
        bad++; $display("FAIL rnd_run job=%0d got=%0d/%b required=%0d/%b", n, rc, err, exp_rc, exp_err);
      end
      if (terr !== terr_m) begin
        bad++; $display("FAIL rnd_timeout_err job=%0d got=%b required=%b", n, terr, terr_m);
      end
      if (held != rdy || ba !== 1'b0) begin
        bad++; $display("FAIL rnd_resp_hold job=%0d got=%0d/%b required=%0d/0", n, held, ba, rdy);
      end
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        terr_m = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_timeout();
    test_withdraw();
    test_reset_mid_run();
    test_stray_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
